insn_encode: RTL and testbench
==============================

// Module: insn_encode
// PURPOSE
//  Inverse of the decode stage: accepts one decoded MIPS instruction per handshake
//  (opcode/rs/rt/rd/sa/func/imm fields, in the decode stage's output field layout)
//  and assembles the 32-bit machine word.
//  Words are buffered in a small FIFO and written sequentially into instruction
//  memory from a programmable start address.
//  Used by the loader/self-test path to build instruction streams for the fetch/decode stages.
// PARAMETERS
//  FIFO_DEPTH  2   output buffer entries (power of 2, >=2)
//  ERR_W       8   width of saturating illegal-instruction counter
// PORTS
//  clock       in   1   single clock; all state updates on posedge
//  reset_n     in   1   asynchronous, active-low reset
//  start       in   1   one-cycle pulse; begins a session (honoured in IDLE only)
//  start_addr  in   32  first write address; bits [1:0] forced to 0
//  in_valid    in   1   field bundle valid
//  in_ready    out  1   encoder accepts bundle this cycle
//  last_in     in   1   qualifies accepted bundle as final of session
//  opcode_in   in   6   major opcode
//  rs_in       in   5   rs field
//  rt_in       in   5   rt field
//  rd_in       in   5   rd field
//  sa_in       in   5   shift amount
//  func_in     in   6   R-type function
//  imm_in      in   26  J: target in [25:0]; I: 16-bit immediate in [25:10]
//  mem_we      out  1   write request (FIFO non-empty)
//  mem_addr    out  32  write address of FIFO head
//  mem_wdata   out  32  encoded word at FIFO head
//  mem_ready   in   1   memory accepts write this cycle
//  err_illegal out  1   one-cycle pulse: accepted bundle had unsupported opcode
//  err_count   out  ERR_W  saturating count of illegal bundles since start
//  done        out  1   one-cycle pulse: session complete, all words written
// BEHAVIOUR
//  Reset: state=IDLE, FIFO emptied, address=0; in_ready, mem_we, err_illegal, done = 0;
//   mem_addr=0, mem_wdata=0, err_count=0. Reset mid-session discards buffered words.
//  FSM: IDLE -start-> RUN (addr<=start_addr&~3, err_count<=0).
//   RUN -accept with last_in-> DRAIN.
//   DRAIN -FIFO empty-> DONE.
//   DONE -> IDLE (done=1 in DONE only).
//   start outside IDLE is ignored.
//  Accept: in_valid && in_ready; in_ready = (state==RUN) && (count<FIFO_DEPTH).
//   No pass-through when full, even if a pop occurs the same cycle.
//  Encoding (registered into FIFO tail on accept):
//   opcode 000000           -> {opcode, rs, rt, rd, sa, func}
//   opcode 000010/000011    -> {opcode, imm[25:0]}
//   opcode in {001000,001001,001010,001011,001101,001110,100011,101011,
//    100000,101000,100100,000100,000101,000111} -> {opcode, rs, rt, imm[25:10]}
//   any other opcode: nothing pushed, err_illegal=1 next cycle, err_count+1 (saturate
//    at all-ones), address unchanged; a last_in on an illegal bundle still -> DRAIN.
//  Latency: bundle accepted at edge N -> mem_we/mem_wdata valid after edge N (cycle N+1).
//  Write: transfer when mem_we && mem_ready; FIFO pops, address += 4 (mod 2^32 wrap).
//   mem_addr/mem_wdata held stable while mem_we && !mem_ready.
//  Simultaneous push and pop: count unchanged, order preserved.
//  Words written in acceptance order, consecutive addresses, no gaps.
// TESTING
//  start_addr=0x100; add rs1 rt2 rd3 func 100000 -> mem_addr 0x100, wdata 0x00221820.
//  addiu rt2 rs0 imm[25:10]=0x0005 then beq rs1 rt2 imm=0xFFFF ->
//   0x24020005 @0x100, 0x1022FFFF @0x104.
//  j imm=26'h0100040 with last_in, mem_ready=1 -> 0x08100040 written;
//   done pulses once two cycles later; state returns IDLE.
//  opcode 111111 -> no write, err_illegal pulse, err_count=1, next legal word still @ same address.
//  mem_ready=0 for 6 cycles, 3 bundles offered -> in_ready drops after 2 accepts,
//   mem_wdata stable; all 3 written in order once mem_ready=1.
//  start_addr=0xFFFFFFFC, 2 words -> addresses 0xFFFFFFFC then 0x00000000;
//   reset_n low mid-session -> mem_we=0, FIFO empty, IDLE.

Source files
------------

// File: rtl/insn_encode.sv
// Assembles decoded MIPS field bundles into 32-bit machine words, buffers them in a
// small FIFO and writes them to consecutive instruction-memory addresses.
module insn_encode #(
  parameter int FIFO_DEPTH = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      start_addr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             last_in,
  input  logic [5:0]       opcode_in,
  input  logic [4:0]       rs_in,
  input  logic [4:0]       rt_in,
  input  logic [4:0]       rd_in,
  input  logic [4:0]       sa_in,
  input  logic [5:0]       func_in,
  input  logic [25:0]      imm_in,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ready,
  output logic             err_illegal,
  output logic [ERR_W-1:0] err_count,
  output logic             done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic        ok;
    logic [31:0] word;
  } enc_t;

  function automatic enc_t encode(input logic [5:0] op, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [4:0] sa, input logic [5:0] fn,
                                  input logic [25:0] imm);
    enc_t e;
    e.ok   = 1'b1;
    e.word = '0;
    case (op)
      6'b000000:            e.word = {op, rs, rt, rd, sa, fn};
      6'b000010, 6'b000011: e.word = {op, imm};
      6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001101, 6'b001110,
      6'b100011, 6'b101011, 6'b100000, 6'b101000, 6'b100100,
      6'b000100, 6'b000101, 6'b000111:
                            e.word = {op, rs, rt, imm[25:10]};
      default:              e.ok   = 1'b0;
    endcase
    return e;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]        addr_q, addr_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               err_ill_q, err_ill_d;
  logic [31:0]        fifo_mem [FIFO_DEPTH];

  enc_t enc;
  logic accept, push, pop;

  assign enc      = encode(opcode_in, rs_in, rt_in, rd_in, sa_in, func_in, imm_in);
  assign in_ready = (state_q == S_RUN) && (count_q < DEPTH_C);
  assign accept   = in_valid && in_ready;
  assign push     = accept && enc.ok;
  assign pop      = mem_we && mem_ready;

  // NOTE: every variable gets its default first so no path through the block
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    addr_d    = addr_q;
    err_cnt_d = err_cnt_q;
    err_ill_d = accept && !enc.ok;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      addr_d   = addr_q + 32'd4;
    end
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (accept && !enc.ok && !(&err_cnt_q)) err_cnt_d = err_cnt_q + ERR_W'(1);

    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_RUN;
        addr_d    = start_addr & ~32'h3;
        err_cnt_d = '0;
      end
      S_RUN:   if (accept && last_in) state_d = S_DRAIN;
      S_DRAIN: if (count_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      addr_q    <= '0;
      err_cnt_q <= '0;
      err_ill_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      addr_q    <= addr_d;
      err_cnt_q <= err_cnt_d;
      err_ill_q <= err_ill_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an empty FIFO (count 0)
  // already makes its contents irrelevant, and the read port is masked below.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= enc.word;
  end

  assign mem_we      = (count_q != '0);
  assign mem_addr    = addr_q;
  assign mem_wdata   = mem_we ? fifo_mem[rd_ptr_q] : 32'h0;
  assign err_illegal = err_ill_q;
  assign err_count   = err_cnt_q;
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_insn_encode.sv
// Self-checking bench for insn_encode: directed scenarios with literal expectations
// plus randomized sessions compared every cycle against a queue-based model.
module tb_insn_encode;

  localparam int DEPTH = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic        clock = 1'b0;
  logic        reset_n, start, in_valid, last_in, mem_ready;
  logic [31:0] start_addr;
  logic [5:0]  opcode_in, func_in;
  logic [4:0]  rs_in, rt_in, rd_in, sa_in;
  logic [25:0] imm_in;
  logic        in_ready, mem_we, err_illegal, done;
  logic [31:0] mem_addr, mem_wdata;
  logic [7:0]  err_count;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int          m_state;
  bit [31:0]   m_q[$];
  bit [31:0]   m_addr;
  int          m_err;
  bit          m_ill;
  bit          m_acc;

  int i_ops[14] = '{8, 9, 10, 11, 13, 14, 35, 43, 32, 40, 36, 4, 5, 7};

  insn_encode #(.FIFO_DEPTH(DEPTH), .ERR_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .last_in(last_in),
    .opcode_in(opcode_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .sa_in(sa_in), .func_in(func_in), .imm_in(imm_in),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .err_illegal(err_illegal), .err_count(err_count),
    .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] ref_word(input bit [31:0] op, rs, rt, rd, sa, fn, imm,
                                         output bit ok);
    ok = 1'b1;
    if (op == 0) return (op << 26) | (rs << 21) | (rt << 16) | (rd << 11) | (sa << 6) | fn;
    if (op == 2 || op == 3) return (op << 26) | imm;
    foreach (i_ops[k]) if (op == i_ops[k]) return (op << 26) | (rs << 21) | (rt << 16) | (imm >> 10);
    ok = 1'b0;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_q.delete();
    m_addr = 0;
    m_err = 0;
    m_ill = 0;
    m_acc = 0;
  endtask

  task automatic model_step();
    bit rdy, pop, was_empty, ok;
    bit [31:0] w;
    if (!reset_n) begin
      model_reset();
      return;
    end
    rdy = (m_state == M_RUN) && (m_q.size() < DEPTH);
    m_acc = in_valid && rdy;
    pop = (m_q.size() > 0) && mem_ready;
    was_empty = (m_q.size() == 0);
    w = ref_word(opcode_in, rs_in, rt_in, rd_in, sa_in, func_in, imm_in, ok);
    m_ill = m_acc && !ok;
    if (pop) begin
      void'(m_q.pop_front());
      m_addr += 4;
    end
    if (m_acc && ok) m_q.push_back(w);
    if (m_acc && !ok && m_err < 255) m_err++;
    case (m_state)
      M_IDLE:  if (start) begin m_state = M_RUN; m_addr = start_addr & ~32'h3; m_err = 0; end
      M_RUN:   if (m_acc && last_in) m_state = M_DRAIN;
      M_DRAIN: if (was_empty) m_state = M_DONE;
      default: m_state = M_IDLE;
    endcase
  endtask

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clock) begin
    check("mem_we", mem_we, m_q.size() > 0);
    check("mem_addr", mem_addr, m_addr);
    check("mem_wdata", mem_wdata, (m_q.size() > 0) ? m_q[0] : 32'h0);
    check("in_ready", in_ready, (m_state == M_RUN) && (m_q.size() < DEPTH));
    check("err_illegal", err_illegal, m_ill);
    check("err_count", err_count, m_err);
    check("done", done, m_state == M_DONE);
  end

  task automatic cyc();
    @(posedge clock);
    model_step();
    #2;
  endtask

  task automatic at_neg();
    @(negedge clock);
    #1;
  endtask

  task automatic begin_session(input logic [31:0] a);
    start = 1'b1;
    start_addr = a;
    cyc();
    start = 1'b0;
  endtask

  task automatic send(input bit [5:0] op, input bit [4:0] rs, rt, rd, sa,
                      input bit [5:0] fn, input bit [25:0] imm, input bit last);
    opcode_in = op; rs_in = rs; rt_in = rt; rd_in = rd; sa_in = sa;
    func_in = fn; imm_in = imm; last_in = last; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (m_acc) break;
    end
    check("accept_timeout", m_acc, 1'b1);
    in_valid = 1'b0;
    last_in = 1'b0;
  endtask

  task automatic wait_idle();
    mem_ready = 1'b1;
    in_valid = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (m_state == M_IDLE) break;
      cyc();
    end
    check("idle_timeout", m_state == M_IDLE, 1'b1);
  endtask

  task automatic rand_fields();
    int r;
    r = $urandom_range(0, 5);
    case (r)
      0:       opcode_in = 6'd0;
      1:       opcode_in = 6'($urandom_range(2, 3));
      2, 3:    opcode_in = 6'(i_ops[$urandom_range(0, 13)]);
      default: opcode_in = 6'($urandom);
    endcase
    rs_in = 5'($urandom); rt_in = 5'($urandom); rd_in = 5'($urandom);
    sa_in = 5'($urandom); func_in = 6'($urandom); imm_in = 26'($urandom);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; start = 1'b0; start_addr = 0; in_valid = 1'b0; last_in = 1'b0;
    mem_ready = 1'b0; opcode_in = 0; rs_in = 0; rt_in = 0; rd_in = 0; sa_in = 0;
    func_in = 0; imm_in = 0;
    model_reset();
    cyc(); cyc();
    at_neg();
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_in_ready", in_ready, 1'b0);
    reset_n = 1'b1;

    // add -> 0x00221820 @0x100
    begin_session(32'h100);
    send(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 26'd0, 1'b1);
    at_neg();
    check("lit_add_addr", mem_addr, 32'h100);
    check("lit_add_word", mem_wdata, 32'h00221820);
    wait_idle();

    // addiu / beq pair
    begin_session(32'h100);
    mem_ready = 1'b0;
    send(6'b001001, 5'd0, 5'd2, 5'd0, 5'd0, 6'd0, 26'(16'h0005) << 10, 1'b0);
    at_neg();
    check("lit_addiu_word", mem_wdata, 32'h24020005);
    check("lit_addiu_addr", mem_addr, 32'h100);
    send(6'b000100, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 26'(16'hFFFF) << 10, 1'b1);
    mem_ready = 1'b1;
    cyc();
    at_neg();
    check("lit_beq_word", mem_wdata, 32'h1022FFFF);
    check("lit_beq_addr", mem_addr, 32'h104);
    wait_idle();

    // j with last_in, done timing
    begin_session(32'h300);
    mem_ready = 1'b1;
    send(6'b000010, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 26'h0100040, 1'b1);
    at_neg();
    check("lit_j_word", mem_wdata, 32'h08100040);
    cyc(); at_neg();
    check("lit_done_n1", done, 1'b0);
    cyc(); at_neg();
    check("lit_done_n2", done, 1'b1);
    cyc(); at_neg();
    check("lit_done_n3", done, 1'b0);
    check("lit_idle_ready", in_ready, 1'b0);

    // illegal opcode keeps address
    begin_session(32'h200);
    send(6'b111111, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 26'd1, 1'b0);
    at_neg();
    check("lit_ill_pulse", err_illegal, 1'b1);
    check("lit_ill_count", err_count, 8'd1);
    check("lit_ill_nowrite", mem_we, 1'b0);
    send(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 26'd0, 1'b1);
    at_neg();
    check("lit_ill_addr", mem_addr, 32'h200);
    wait_idle();

    // stalled memory, three bundles offered
    begin_session(32'h400);
    mem_ready = 1'b0;
    opcode_in = 0; rs_in = 1; rt_in = 2; rd_in = 1; sa_in = 0; func_in = 6'b100000;
    imm_in = 0; last_in = 1'b0; in_valid = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (m_acc) begin
        n++;
        rd_in = 5'(n + 1);
        last_in = (n == 2);
      end
    end
    at_neg();
    check("lit_stall_ready", in_ready, 1'b0);
    check("lit_stall_accepts", n, 2);
    check("lit_stall_head", mem_wdata, 32'h00220820);
    mem_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (m_acc) break;
    end
    check("stall_third_accept", m_acc, 1'b1);
    in_valid = 1'b0;
    wait_idle();

    // address wrap
    begin_session(32'hFFFF_FFFC);
    mem_ready = 1'b0;
    send(6'b000011, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 26'h1, 1'b0);
    send(6'b000011, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 26'h2, 1'b1);
    at_neg();
    check("lit_wrap_a0", mem_addr, 32'hFFFF_FFFC);
    mem_ready = 1'b1;
    cyc(); at_neg();
    check("lit_wrap_a1", mem_addr, 32'h0000_0000);
    check("lit_wrap_w1", mem_wdata, 32'h0C000002);
    wait_idle();

    // reset mid-session
    begin_session(32'h500);
    mem_ready = 1'b0;
    send(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 26'd0, 1'b0);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("lit_midrst_we", mem_we, 1'b0);
    check("lit_midrst_addr", mem_addr, 32'h0);
    cyc(); cyc();
    reset_n = 1'b1;
    at_neg();
    check("lit_midrst_idle", in_ready, 1'b0);

    // err_count saturation
    begin_session(32'h600);
    mem_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      rand_fields();
      opcode_in = 6'b111111;
      cyc();
    end
    in_valid = 1'b0;
    at_neg();
    check("lit_err_sat", err_count, 8'hFF);
    send(6'b000010, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 26'h3, 1'b1);
    wait_idle();

    // randomized sessions
    for (int s = 0; s < 16; s++) begin
      begin_session((s % 4 == 3) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom);
      for (int k = 0; k < 400; k++) begin
        rand_fields();
        in_valid = ($urandom_range(0, 3) != 0);
        last_in = ($urandom_range(0, 9) == 0);
        mem_ready = ($urandom_range(0, 2) != 0);
        start = ($urandom_range(0, 15) == 0);
        cyc();
        if (m_state == M_IDLE) break;
      end
      last_in = 1'b0;
      if (m_state == M_RUN) send(6'd0, 5'd4, 5'd5, 5'd6, 5'd7, 6'd8, 26'd0, 1'b1);
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
